// File: rtl/uart_rx_ctrl_if.sv
// Receiver handshake and FIFO stream signals shared by uart_rx_ctrl and its neighbours.
// master = the sequencer side, slave = receiver plus downstream consumer.
interface uart_rx_ctrl_if;
  logic        uart_en;
  logic        uart_rx_busy;
  logic        uart_rx_done;
  logic        rx_err_flag;
  logic [15:0] rx_data;
  logic        m_valid;
  logic        m_ready;
  logic [16:0] m_data;

  modport master (
    output uart_en,
    output m_valid,
    output m_data,
    input  uart_rx_busy,
    input  uart_rx_done,
    input  rx_err_flag,
    input  rx_data,
    input  m_ready
  );

  modport slave (
    input  uart_en,
    input  m_valid,
    input  m_data,
    output uart_rx_busy,
    output uart_rx_done,
    output rx_err_flag,
    output rx_data,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: arms the receiver, captures each finished frame into a small
// FIFO, and tracks overflow, timeout and frame count.
module uart_rx_ctrl #(
  parameter int DEPTH = 4,
  parameter int TO_W  = 24
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            run,
  input  logic [3:0]      data_num,
  input  logic [TO_W-1:0] to_limit,
  input  logic            clr_sticky,
  uart_rx_ctrl_if.master  bus,
  output logic [4:0]      fifo_cnt,
  output logic            ovf_flag,
  output logic            to_flag,
  output logic [15:0]     frame_cnt,
  output logic            ctrl_busy
);

  localparam int         PW        = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            done_q, done_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_flag_q, to_flag_d;
  logic            ovf_flag_q, ovf_flag_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [16:0]     mem_q [DEPTH];
  logic [16:0]     mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      cnt_q, cnt_d;

  logic            done_rise;
  logic            to_hit;
  logic            push_req;
  logic            pop;
  logic            full;
  logic            push_ok;
  logic            ovf_hit;
  logic [15:0]     mask;
  logic [16:0]     push_word;

  assign done_rise = bus.uart_rx_done & ~done_q;
  assign done_d    = bus.uart_rx_done;

  // The timeout counter saturates at to_limit so the flag fires only once per wait.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    to_hit   = 1'b0;
    push_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_ARM;
      end
      S_ARM: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          state_d = S_CAPT;
        end else if ((to_limit != '0) && (to_cnt_q < to_limit)) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          to_hit   = (to_cnt_d == to_limit);
        end
      end
      S_CAPT: begin
        push_req = 1'b1;
        state_d  = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.uart_rx_done && !bus.uart_rx_busy) state_d = run ? S_ARM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mask      = (data_num == 4'd0) ? 16'hFFFF : ((16'd1 << data_num) - 16'd1);
  assign push_word = {bus.rx_err_flag, bus.rx_data & mask};

  assign pop     = (cnt_q != 5'd0) && bus.m_ready;
  assign full    = (cnt_q == DEPTH_CNT);
  assign push_ok = push_req && (!full || pop);
  assign ovf_hit = push_req && full && !pop;

  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    frame_cnt_d = push_req ? (frame_cnt_q + 16'd1) : frame_cnt_q;
    ovf_flag_d  = ovf_hit ? 1'b1 : (clr_sticky ? 1'b0 : ovf_flag_q);
    to_flag_d   = to_hit  ? 1'b1 : (clr_sticky ? 1'b0 : to_flag_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      to_cnt_q    <= '0;
      to_flag_q   <= 1'b0;
      ovf_flag_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= 5'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 17'd0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      to_cnt_q    <= to_cnt_d;
      to_flag_q   <= to_flag_d;
      ovf_flag_q  <= ovf_flag_d;
      frame_cnt_q <= frame_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.uart_en = (state_q == S_ARM);
  assign bus.m_valid = (cnt_q != 5'd0);
  assign bus.m_data  = mem_q[rd_ptr_q];
  assign fifo_cnt    = cnt_q;
  assign ovf_flag    = ovf_flag_q;
  assign to_flag     = to_flag_q;
  assign frame_cnt   = frame_cnt_q;
  assign ctrl_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed plus randomized bench for uart_rx_ctrl; a queue-based model of the frame FIFO
// and counters supplies every expected value.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int TO_W  = 24;

  logic            clk = 1'b0;
  logic            rstn;
  logic            run;
  logic [3:0]      data_num;
  logic [TO_W-1:0] to_limit;
  logic            clr_sticky;
  logic [4:0]      fifo_cnt;
  logic            ovf_flag;
  logic            to_flag;
  logic [15:0]     frame_cnt;
  logic            ctrl_busy;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .TO_W(TO_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .run        (run),
    .data_num   (data_num),
    .to_limit   (to_limit),
    .clr_sticky (clr_sticky),
    .bus        (bus),
    .fifo_cnt   (fifo_cnt),
    .ovf_flag   (ovf_flag),
    .to_flag    (to_flag),
    .frame_cnt  (frame_cnt),
    .ctrl_busy  (ctrl_busy)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [16:0] exp_q[$];
  logic        exp_ovf;
  logic [15:0] exp_frames;
  int          pulses;
  logic [15:0] d_t6;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] maskFor(input logic [3:0] n);
    if (n == 4'd0) return 16'hFFFF;
    return 16'((32'd1 << n) - 32'd1);
  endfunction

  // Model of one captured frame: kept if room (or the head leaves now), else dropped.
  task automatic modelCapture(input logic [15:0] d, input logic e, input bit pop);
    exp_frames++;
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_q.size() < DEPTH) exp_q.push_back({e, d & maskFor(data_num)});
    else exp_ovf = 1'b1;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_fifo_cnt"}, 32'(fifo_cnt), 32'(exp_q.size()));
    checkOutput({tag, "_ovf"}, 32'(ovf_flag), 32'(exp_ovf));
    checkOutput({tag, "_frames"}, 32'(frame_cnt), 32'(exp_frames));
    if (exp_q.size() > 0) begin
      checkOutput({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
      checkOutput({tag, "_head"}, 32'(bus.m_data), 32'(exp_q[0]));
    end
  endtask

  task automatic waitArm(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus.uart_en) seen = 1'b1;
      else tick();
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  // Called at a negedge in WAIT; returns two cycles after the done rise.
  task automatic captureFrame(input logic [15:0] d, input logic e, input bit popInCapt);
    bus.uart_rx_busy = 1'b0;
    bus.uart_rx_done = 1'b1;
    bus.rx_data      = d;
    bus.rx_err_flag  = e;
    tick();
    modelCapture(d, e, popInCapt);
    if (popInCapt) bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic e, input int busyCyc,
                               input bit popInCapt, input bit dropRun);
    waitArm("arm");
    bus.uart_rx_busy = 1'b1;
    bus.rx_data      = 16'($urandom);
    if (dropRun) run = 1'b0;
    tick();
    checkOutput("arm_pulse_width", 32'(bus.uart_en), 32'd0);
    repeat (busyCyc - 1) tick();
    captureFrame(d, e, popInCapt);
  endtask

  task automatic releaseDone(input int hold);
    repeat (hold) tick();
    bus.uart_rx_done = 1'b0;
    bus.rx_data      = 16'($urandom);
    tick();
  endtask

  task automatic drainAll(input string tag);
    bus.m_ready = 1'b1;
    while (exp_q.size() > 0) begin
      checkOutput({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
      checkOutput({tag, "_data"}, 32'(bus.m_data), 32'(exp_q[0]));
      tick();
      void'(exp_q.pop_front());
    end
    bus.m_ready = 1'b0;
    checkOutput({tag, "_empty"}, 32'(fifo_cnt), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0; run = 1'b0; data_num = 4'd8; to_limit = '0; clr_sticky = 1'b0;
    bus.uart_rx_busy = 1'b0; bus.uart_rx_done = 1'b0; bus.rx_err_flag = 1'b0;
    bus.rx_data = 16'd0; bus.m_ready = 1'b0;
    exp_ovf = 1'b0; exp_frames = 16'd0;
    repeat (3) tick();

    checkOutput("rst_uart_en", 32'(bus.uart_en), 32'd0);
    checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(bus.m_data), 32'd0);
    checkOutput("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_flag), 32'd0);
    checkOutput("rst_to", 32'(to_flag), 32'd0);
    checkOutput("rst_frames", 32'(frame_cnt), 32'd0);
    checkOutput("rst_busy", 32'(ctrl_busy), 32'd0);
    rstn = 1'b1;
    repeat (2) tick();
    checkOutput("idle_busy", 32'(ctrl_busy), 32'd0);
    checkOutput("idle_en", 32'(bus.uart_en), 32'd0);

    // T1: single 8-bit frame, visible two cycles after done rises
    run = 1'b1; data_num = 4'd8;
    applyStimulus(16'h12A5, 1'b0, 3, 1'b0, 1'b0);
    checkOutput("t1_valid", 32'(bus.m_valid), 32'd1);
    checkOutput("t1_data", 32'(bus.m_data), 32'h000A5);
    checkOutput("t1_frames", 32'(frame_cnt), 32'd1);
    checkState("t1");
    drainAll("t1_drain");
    releaseDone(2);
    waitArm("t1_rearm");

    // T2: five random frames with no consumer overflow a 4-entry FIFO
    for (int i = 0; i < 5; i++) begin
      data_num = 4'($urandom_range(0, 15));
      applyStimulus(16'($urandom), 1'($urandom), int'($urandom_range(1, 5)), 1'b0, 1'b0);
      checkState("t2");
      releaseDone(int'($urandom_range(0, 3)));
    end
    checkOutput("t2_cnt", 32'(fifo_cnt), 32'd4);
    checkOutput("t2_ovf", 32'(ovf_flag), 32'd1);
    checkOutput("t2_frames", 32'(frame_cnt), 32'd6);

    // T3: clear the sticky flag, then push into a full FIFO while the head pops
    waitArm("t3_arm");
    bus.uart_rx_busy = 1'b1;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checkOutput("t3_ovf_clr", 32'(ovf_flag), 32'd0);
    exp_ovf = 1'b0;
    tick();
    checkOutput("t2_head", 32'(bus.m_data), 32'(exp_q[0]));
    data_num = 4'd12;
    captureFrame(16'($urandom), 1'b1, 1'b1);
    checkOutput("t3_ovf", 32'(ovf_flag), 32'd0);
    checkOutput("t3_cnt", 32'(fifo_cnt), 32'd4);
    checkState("t3");
    drainAll("t3_drain");
    releaseDone(1);

    // T4: done never rises; timeout flags after 100 WAIT cycles and state holds
    to_limit = 24'd100;
    waitArm("t4_arm");
    bus.uart_rx_busy = 1'b1;
    repeat (100) tick();
    checkOutput("t4_before", 32'(to_flag), 32'd0);
    tick();
    checkOutput("t4_set", 32'(to_flag), 32'd1);
    repeat (20) tick();
    checkOutput("t4_sticky", 32'(to_flag), 32'd1);
    checkOutput("t4_busy", 32'(ctrl_busy), 32'd1);
    checkOutput("t4_no_rearm", 32'(bus.uart_en), 32'd0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checkOutput("t4_clr", 32'(to_flag), 32'd0);
    repeat (10) tick();
    checkOutput("t4_stays_clr", 32'(to_flag), 32'd0);
    checkOutput("t4_hold", 32'(ctrl_busy), 32'd1);
    captureFrame(16'($urandom), 1'b0, 1'b0);
    to_limit = '0;
    checkState("t4");
    drainAll("t4_drain");
    releaseDone(1);

    // T5: run dropped during WAIT; frame still lands, then the sequencer parks
    applyStimulus(16'($urandom), 1'($urandom), 4, 1'b0, 1'b1);
    checkState("t5");
    releaseDone(1);
    checkOutput("t5_idle", 32'(ctrl_busy), 32'd0);
    pulses = 0;
    repeat (30) begin
      if (bus.uart_en) pulses++;
      tick();
    end
    checkOutput("t5_no_arm", 32'(pulses), 32'd0);
    drainAll("t5_drain");

    // Randomized frames with occasional draining
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_num = 4'($urandom_range(0, 15));
      applyStimulus(16'($urandom), 1'($urandom), int'($urandom_range(1, 6)), 1'b0, 1'b0);
      checkState("rnd");
      if ($urandom_range(0, 2) == 0 || i == 9) drainAll("rnd_drain");
      releaseDone(int'($urandom_range(0, 2)));
    end

    // T6: two queued frames, then reset while waiting on a third
    for (int i = 0; i < 2; i++) begin
      data_num = 4'($urandom_range(0, 15));
      applyStimulus(16'($urandom), 1'($urandom), 2, 1'b0, 1'b0);
      releaseDone(1);
    end
    waitArm("t6_arm");
    bus.uart_rx_busy = 1'b1;
    repeat (3) tick();
    checkOutput("t6_pre_cnt", 32'(fifo_cnt), 32'd2);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t6_uart_en", 32'(bus.uart_en), 32'd0);
    checkOutput("t6_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("t6_m_data", 32'(bus.m_data), 32'd0);
    checkOutput("t6_fifo_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("t6_ovf", 32'(ovf_flag), 32'd0);
    checkOutput("t6_to", 32'(to_flag), 32'd0);
    checkOutput("t6_frames", 32'(frame_cnt), 32'd0);
    checkOutput("t6_busy", 32'(ctrl_busy), 32'd0);
    exp_q.delete(); exp_ovf = 1'b0; exp_frames = 16'd0;
    run = 1'b0; bus.uart_rx_busy = 1'b0; bus.uart_rx_done = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Full 16-bit frame with parity error keeps every data bit
    run = 1'b1; data_num = 4'd0;
    d_t6 = 16'($urandom);
    applyStimulus(d_t6, 1'b1, 2, 1'b0, 1'b0);
    checkOutput("err_full_data", 32'(bus.m_data), 32'({1'b1, d_t6}));
    checkState("err");
    run = 1'b0;
    drainAll("err_drain");
    releaseDone(1);
    checkOutput("final_idle", 32'(ctrl_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
